// File: rtl/imsic_pkg.sv
// rtl/imsic_pkg.sv - shared types and field layout for the IMSIC MSI-info transfer
// Contents:
//   default field widths and bit offsets of the {hart, file, src} info word,
//   the receive FSM state encoding, and the drop counter width.
package imsic_pkg;

  localparam int NR_SRC_WIDTH_DEF    = 5;
  localparam int INTP_FILE_WIDTH_DEF = 3;
  localparam int NR_HARTS_WIDTH_DEF  = 6;
  localparam int NR_HARTS_DEF        = 64;
  localparam int NR_INTP_FILES_DEF   = 7;

  // src always sits at the bottom of the info word
  localparam int SRC_LSB = 0;

  localparam int DROP_CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    ARM      = 2'd0,
    IDLE     = 2'd1,
    DEC      = 2'd2,
    WAIT_LOW = 2'd3
  } state_e;

  // file field starts right above src
  function automatic int file_lsb(input int src_w);
    return SRC_LSB + src_w;
  endfunction

  // hart field starts right above file
  function automatic int hart_lsb(input int src_w, input int file_w);
    return SRC_LSB + src_w + file_w;
  endfunction

endpackage

// File: rtl/imsic_sync2.sv
// rtl/imsic_sync2.sv - parameterized-width two-flop synchronizer
// Ports:
//   clk  - destination-domain clock
//   rst  - asynchronous active-high reset, clears both stages to 0
//   d_i  - asynchronous input level(s)
//   q_o  - synchronized level(s), two clk edges behind d_i
module imsic_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/imsic_msi_rcv.sv
// rtl/imsic_msi_rcv.sv - IMSIC MSI-info receiver: sync, capture, decode, strobe or drop
// Ports:
//   clk            - receive-domain clock
//   rst            - asynchronous active-high reset
//   i_msi_info     - {hart, file, src}, stable while i_msi_info_vld is high
//   i_msi_info_vld - asynchronous level, one assertion per MSI
//   hart_id        - this hart's index, quasi-static
//   o_setipnum     - last accepted interrupt identity
//   o_setipnum_we  - one-hot single-cycle write strobe to the addressed file
//   o_msi_drop     - single-cycle pulse for a rejected MSI
//   o_drop_cnt     - saturating rejected-MSI count
module imsic_msi_rcv
  import imsic_pkg::*;
#(
  parameter  int NR_SRC_WIDTH    = NR_SRC_WIDTH_DEF,
  parameter  int INTP_FILE_WIDTH = INTP_FILE_WIDTH_DEF,
  parameter  int NR_HARTS_WIDTH  = NR_HARTS_WIDTH_DEF,
  parameter  int NR_HARTS        = NR_HARTS_DEF,
  parameter  int NR_INTP_FILES   = NR_INTP_FILES_DEF,
  localparam int MSI_INFO_WIDTH  = NR_HARTS_WIDTH + INTP_FILE_WIDTH + NR_SRC_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MSI_INFO_WIDTH-1:0] i_msi_info,
  input  logic                      i_msi_info_vld,
  input  logic [NR_HARTS_WIDTH-1:0] hart_id,
  output logic [NR_SRC_WIDTH-1:0]   o_setipnum,
  output logic [NR_INTP_FILES-1:0]  o_setipnum_we,
  output logic                      o_msi_drop,
  output logic [DROP_CNT_WIDTH-1:0] o_drop_cnt
);

  localparam int FILE_LSB = file_lsb(NR_SRC_WIDTH);
  localparam int HART_LSB = hart_lsb(NR_SRC_WIDTH, INTP_FILE_WIDTH);

  logic vld_s;

  imsic_sync2 #(
    .WIDTH (1)
  ) u_vld_sync (
    .clk (clk),
    .rst (rst),
    .d_i (i_msi_info_vld),
    .q_o (vld_s)
  );

  state_e                      state_q, state_d;
  logic [MSI_INFO_WIDTH-1:0]   info_q, info_d;
  logic [NR_SRC_WIDTH-1:0]     setipnum_q, setipnum_d;
  logic [NR_INTP_FILES-1:0]    we_q, we_d;
  logic                        drop_q, drop_d;
  logic [DROP_CNT_WIDTH-1:0]   cnt_q, cnt_d;

  // The synchronizer comes out of reset showing 0 regardless of the real
  // level, so ARM only trusts vld_s once two edges have passed since release.
  // Otherwise a level held high through reset would look like a fresh rise.
  logic [1:0] prime_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prime_q <= 2'b00;
    end else begin
      prime_q <= {prime_q[0], 1'b1};
    end
  end

  logic [NR_SRC_WIDTH-1:0]    src_f;
  logic [INTP_FILE_WIDTH-1:0] file_f;
  logic [NR_HARTS_WIDTH-1:0]  hart_f;

  assign src_f  = info_q[SRC_LSB  +: NR_SRC_WIDTH];
  assign file_f = info_q[FILE_LSB +: INTP_FILE_WIDTH];
  assign hart_f = info_q[HART_LSB +: NR_HARTS_WIDTH];

  logic                     hart_ok;
  logic                     file_ok;
  logic                     src_ok;
  logic                     accept;
  logic [NR_INTP_FILES-1:0] file_onehot;

  assign hart_ok = (NR_HARTS == 1) || (hart_f == hart_id);
  assign file_ok = int'(file_f) < NR_INTP_FILES;
  assign src_ok  = (src_f != '0);
  assign accept  = hart_ok && file_ok && src_ok;

  always_comb begin
    file_onehot = '0;
    for (int i = 0; i < NR_INTP_FILES; i++) begin
      if (int'(file_f) == i) begin
        file_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    info_d     = info_q;
    setipnum_d = setipnum_q;
    we_d       = '0;
    drop_d     = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      ARM: begin
        if (prime_q[1] && !vld_s) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (vld_s) begin
          info_d  = i_msi_info;
          state_d = DEC;
        end
      end
      DEC: begin
        state_d = WAIT_LOW;
        if (accept) begin
          setipnum_d = src_f;
          we_d       = file_onehot;
        end else begin
          drop_d = 1'b1;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + DROP_CNT_WIDTH'(1);
          end
        end
      end
      WAIT_LOW: begin
        if (!vld_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = ARM;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARM;
      info_q     <= '0;
      setipnum_q <= '0;
      we_q       <= '0;
      drop_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      info_q     <= info_d;
      setipnum_q <= setipnum_d;
      we_q       <= we_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_setipnum    = setipnum_q;
  assign o_setipnum_we = we_q;
  assign o_msi_drop    = drop_q;
  assign o_drop_cnt    = cnt_q;

endmodule
